// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported, variable-latency memory between the fetch and data requesters.
// Data normally wins, but a waiting fetch is always granted right after a data access.
module mem_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_data,
  output logic              if_valid,
  input  logic              dm_rd,
  input  logic              dm_wr,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_valid,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err_timeout
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BUSY_I = 2'd1;
  localparam logic [1:0] BUSY_D = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

  logic [1:0] state_reg;
  logic       last_data_reg;
  logic [7:0] wait_reg;

  logic dm_req;
  logic grant_d;
  logic grant_i;
  logic timeout;
  logic done;

  always_comb begin
    dm_req  = dm_rd | dm_wr;
    // A fetch that lost the previous round beats a new data request.
    grant_d = dm_req & ~(last_data_reg & if_req);
    grant_i = ~grant_d & if_req;
    timeout = (wait_reg == WAIT_LIMIT) & ~mem_ack;
    done    = mem_ack | timeout;
  end

  assign stall_if  = if_req & ~if_valid;
  assign stall_mem = dm_req & ~dm_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      last_data_reg <= 1'b0;
      wait_reg      <= 8'd0;
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      if_data       <= '0;
      dm_rdata      <= '0;
      if_valid      <= 1'b0;
      dm_valid      <= 1'b0;
      err_timeout   <= 1'b0;
    end else begin
      if_valid <= 1'b0;
      dm_valid <= 1'b0;
      case (state_reg)
        IDLE: begin
          wait_reg <= 8'd0;
          if (grant_d) begin
            state_reg     <= BUSY_D;
            last_data_reg <= 1'b1;
            mem_req       <= 1'b1;
            mem_addr      <= dm_addr;
            mem_we        <= dm_wr;
            if (dm_wr) begin
              mem_wdata <= dm_wdata;
            end
          end else if (grant_i) begin
            state_reg     <= BUSY_I;
            last_data_reg <= 1'b0;
            mem_req       <= 1'b1;
            mem_addr      <= if_addr;
            mem_we        <= 1'b0;
          end
        end
        BUSY_I, BUSY_D: begin
          if (done) begin
            state_reg <= RESP;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            if (timeout) begin
              err_timeout <= 1'b1;
            end
            // A timed-out access returns zero; an acked write keeps the old read word.
            if (state_reg == BUSY_I) begin
              if_valid <= 1'b1;
              if_data  <= timeout ? '0 : mem_rdata;
            end else begin
              dm_valid <= 1'b1;
              if (timeout) begin
                dm_rdata <= '0;
              end else if (!mem_we) begin
                dm_rdata <= mem_rdata;
              end
            end
          end else begin
            wait_reg <= wait_reg + 8'd1;
          end
        end
        RESP: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: each task walks one scenario cycle by cycle
// against hand-derived expectations.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_data;
  logic        if_valid;
  logic        dm_rd = 1'b0;
  logic        dm_wr = 1'b0;
  logic [31:0] dm_addr = '0;
  logic [31:0] dm_wdata = '0;
  logic [31:0] dm_rdata;
  logic        dm_valid;
  logic        stall_if;
  logic        stall_mem;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        err_timeout;

  int vectors = 0;
  int miscompares = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(15)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_data(if_data), .if_valid(if_valid),
    .dm_rd(dm_rd), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_valid(dm_valid),
    .stall_if(stall_if), .stall_mem(stall_mem),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL rst_mem_req got=%h exp=0", mem_req); end
    vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("FAIL rst_mem_we got=%h exp=0", mem_we); end
    vectors++; if (mem_addr !== 32'h0) begin miscompares++; $display("FAIL rst_mem_addr got=%h exp=0", mem_addr); end
    vectors++; if (mem_wdata !== 32'h0) begin miscompares++; $display("FAIL rst_mem_wdata got=%h exp=0", mem_wdata); end
    vectors++; if (if_data !== 32'h0) begin miscompares++; $display("FAIL rst_if_data got=%h exp=0", if_data); end
    vectors++; if (dm_rdata !== 32'h0) begin miscompares++; $display("FAIL rst_dm_rdata got=%h exp=0", dm_rdata); end
    vectors++; if (if_valid !== 1'b0 || dm_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valids got=%b%b exp=00", if_valid, dm_valid); end
    vectors++; if (err_timeout !== 1'b0) begin miscompares++; $display("FAIL rst_err_timeout got=%h exp=0", err_timeout); end
    tick();
    tick();
    rst = 1'b0;
    // A stray ack while idle must not produce a completion.
    tick();
    mem_ack = 1'b1;
    mem_rdata = 32'h5555AAAA;
    tick();
    mem_ack = 1'b0;
    #1;
    vectors++; if (if_valid !== 1'b0 || dm_valid !== 1'b0) begin miscompares++; $display("FAIL idle_ack_valids got=%b%b exp=00", if_valid, dm_valid); end
    vectors++; if (if_data !== 32'h0) begin miscompares++; $display("FAIL idle_ack_if_data got=%h exp=0", if_data); end
    vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL idle_ack_mem_req got=%h exp=0", mem_req); end
    $display("reset: outputs cleared, idle ack ignored");
  endtask

  task automatic test_single_fetch();
    tick();
    if_req = 1'b1;
    if_addr = 32'h10;
    #1;
    vectors++; if (stall_if !== 1'b1) begin miscompares++; $display("FAIL fetch_c0_stall got=%h exp=1", stall_if); end
    vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL fetch_c0_mem_req got=%h exp=0", mem_req); end
    tick();
    mem_ack = 1'b1;
    mem_rdata = 32'h8C010004;
    #1;
    vectors++; if (mem_req !== 1'b1) begin miscompares++; $display("FAIL fetch_c1_mem_req got=%h exp=1", mem_req); end
    vectors++; if (mem_addr !== 32'h10) begin miscompares++; $display("FAIL fetch_c1_mem_addr got=%h exp=10", mem_addr); end
    vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("FAIL fetch_c1_mem_we got=%h exp=0", mem_we); end
    vectors++; if (stall_if !== 1'b1) begin miscompares++; $display("FAIL fetch_c1_stall got=%h exp=1", stall_if); end
    tick();
    mem_ack = 1'b0;
    #1;
    vectors++; if (if_valid !== 1'b1) begin miscompares++; $display("FAIL fetch_c2_valid got=%h exp=1", if_valid); end
    vectors++; if (if_data !== 32'h8C010004) begin miscompares++; $display("FAIL fetch_c2_data got=%h exp=8c010004", if_data); end
    vectors++; if (stall_if !== 1'b0) begin miscompares++; $display("FAIL fetch_c2_stall got=%h exp=0", stall_if); end
    vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL fetch_c2_mem_req got=%h exp=0", mem_req); end
    tick();
    if_req = 1'b0;
    #1;
    vectors++; if (if_valid !== 1'b0) begin miscompares++; $display("FAIL fetch_c3_valid got=%h exp=0", if_valid); end
    $display("single fetch: addr=%h data=%h", 32'h10, if_data);
  endtask

  task automatic test_contention();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    if_req = 1'b1;
    if_addr = 32'h20;
    dm_rd = 1'b1;
    dm_addr = 32'h40;
    #1;
    vectors++; if (stall_if !== 1'b1 || stall_mem !== 1'b1) begin miscompares++; $display("FAIL cont_c0_stalls got=%b%b exp=11", stall_if, stall_mem); end
    tick();
    mem_ack = 1'b1;
    mem_rdata = 32'hDEADBEEF;
    #1;
    vectors++; if (mem_addr !== 32'h40) begin miscompares++; $display("FAIL cont_d_mem_addr got=%h exp=40", mem_addr); end
    vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("FAIL cont_d_mem_we got=%h exp=0", mem_we); end
    tick();
    mem_ack = 1'b0;
    #1;
    vectors++; if (dm_valid !== 1'b1 || if_valid !== 1'b0) begin miscompares++; $display("FAIL cont_d_valids got=%b%b exp=10", dm_valid, if_valid); end
    vectors++; if (dm_rdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL cont_d_rdata got=%h exp=deadbeef", dm_rdata); end
    vectors++; if (stall_mem !== 1'b0 || stall_if !== 1'b1) begin miscompares++; $display("FAIL cont_d_stalls got=%b%b exp=01", stall_mem, stall_if); end
    tick();
    dm_rd = 1'b0;
    #1;
    vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL cont_idle_mem_req got=%h exp=0", mem_req); end
    tick();
    mem_ack = 1'b1;
    mem_rdata = 32'h11112222;
    #1;
    vectors++; if (mem_req !== 1'b1 || mem_addr !== 32'h20) begin miscompares++; $display("FAIL cont_i_grant got=%h/%h exp=1/20", mem_req, mem_addr); end
    tick();
    mem_ack = 1'b0;
    #1;
    vectors++; if (if_valid !== 1'b1 || if_data !== 32'h11112222) begin miscompares++; $display("FAIL cont_i_done got=%h/%h exp=1/11112222", if_valid, if_data); end
    tick();
    if_req = 1'b0;
    $display("contention: data granted at 40, then fetch at 20");
  endtask

  task automatic test_fairness();
    logic [31:0] wd [2];
    logic        is_d;
    int          j;
    wd[0] = 32'hCAFE0001;
    wd[1] = 32'hCAFE0002;
    tick();
    if_req = 1'b1;
    if_addr = 32'h100;
    dm_wr = 1'b1;
    dm_addr = 32'h200;
    dm_wdata = wd[0];
    for (int k = 0; k < 4; k++) begin
      is_d = (k % 2 == 0);
      j = k / 2;
      tick();
      mem_ack = 1'b1;
      mem_rdata = 32'hFFFF0000 | k;
      #1;
      vectors++; if (mem_req !== 1'b1) begin miscompares++; $display("FAIL fair%0d_mem_req got=%h exp=1", k, mem_req); end
      vectors++; if (mem_we !== is_d) begin miscompares++; $display("FAIL fair%0d_mem_we got=%h exp=%h", k, mem_we, is_d); end
      vectors++; if (mem_addr !== (is_d ? 32'h200 + 4 * j : 32'h100 + 4 * j)) begin miscompares++; $display("FAIL fair%0d_mem_addr got=%h", k, mem_addr); end
      vectors++; if (mem_wdata !== wd[j]) begin miscompares++; $display("FAIL fair%0d_mem_wdata got=%h exp=%h", k, mem_wdata, wd[j]); end
      $display("fairness grant %0d: %s addr=%h we=%b", k, is_d ? "D" : "I", mem_addr, mem_we);
      tick();
      mem_ack = 1'b0;
      #1;
      vectors++; if (dm_valid !== is_d || if_valid !== !is_d) begin miscompares++; $display("FAIL fair%0d_valids got=%b%b", k, dm_valid, if_valid); end
      vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL fair%0d_resp_mem_req got=%h exp=0", k, mem_req); end
      if (is_d) begin
        vectors++; if (dm_rdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL fair%0d_rdata_kept got=%h exp=deadbeef", k, dm_rdata); end
      end else begin
        vectors++; if (if_data !== (32'hFFFF0000 | k)) begin miscompares++; $display("FAIL fair%0d_if_data got=%h", k, if_data); end
      end
      tick();
      if (k == 0) begin
        dm_addr = 32'h204;
        dm_wdata = wd[1];
      end else if (k == 1) begin
        if_addr = 32'h104;
      end else if (k == 3) begin
        dm_wr = 1'b0;
        if_req = 1'b0;
      end
    end
  endtask

  task automatic test_wait_states();
    tick();
    dm_wr = 1'b1;
    dm_addr = 32'h300;
    dm_wdata = 32'hA5A5A5A5;
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c == 2) dm_wdata = 32'h0;
      if (c == 5) begin
        mem_ack = 1'b1;
        mem_rdata = 32'h00000077;
      end
      #1;
      vectors++; if (mem_req !== 1'b1 || mem_we !== 1'b1) begin miscompares++; $display("FAIL wait_c%0d_req_we got=%b%b exp=11", c, mem_req, mem_we); end
      vectors++; if (mem_addr !== 32'h300) begin miscompares++; $display("FAIL wait_c%0d_addr got=%h exp=300", c, mem_addr); end
      vectors++; if (mem_wdata !== 32'hA5A5A5A5) begin miscompares++; $display("FAIL wait_c%0d_wdata got=%h exp=a5a5a5a5", c, mem_wdata); end
      vectors++; if (dm_valid !== 1'b0) begin miscompares++; $display("FAIL wait_c%0d_valid got=%h exp=0", c, dm_valid); end
    end
    tick();
    mem_ack = 1'b0;
    #1;
    vectors++; if (dm_valid !== 1'b1) begin miscompares++; $display("FAIL wait_c6_valid got=%h exp=1", dm_valid); end
    vectors++; if (dm_rdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL wait_c6_rdata got=%h exp=deadbeef", dm_rdata); end
    vectors++; if (stall_mem !== 1'b0) begin miscompares++; $display("FAIL wait_c6_stall got=%h exp=0", stall_mem); end
    $display("wait states: write 300 completed in cycle 6");
    tick();
    dm_wr = 1'b0;
  endtask

  task automatic test_timeout();
    tick();
    dm_rd = 1'b1;
    dm_addr = 32'h400;
    for (int c = 1; c <= 16; c++) begin
      tick();
      vectors++; if (dm_valid !== 1'b0 || mem_req !== 1'b1) begin miscompares++; $display("FAIL tmo_c%0d got valid=%h req=%h exp 0/1", c, dm_valid, mem_req); end
    end
    vectors++; if (err_timeout !== 1'b0) begin miscompares++; $display("FAIL tmo_c16_err got=%h exp=0", err_timeout); end
    tick();
    vectors++; if (dm_valid !== 1'b1) begin miscompares++; $display("FAIL tmo_c17_valid got=%h exp=1", dm_valid); end
    vectors++; if (dm_rdata !== 32'h0) begin miscompares++; $display("FAIL tmo_c17_rdata got=%h exp=0", dm_rdata); end
    vectors++; if (err_timeout !== 1'b1) begin miscompares++; $display("FAIL tmo_c17_err got=%h exp=1", err_timeout); end
    vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL tmo_c17_mem_req got=%h exp=0", mem_req); end
    tick();
    dm_rd = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    vectors++; if (err_timeout !== 1'b1) begin miscompares++; $display("FAIL tmo_sticky got=%h exp=1", err_timeout); end
    $display("timeout: read 400 returned %h err=%b", dm_rdata, err_timeout);
  endtask

  task automatic test_reset_busy();
    tick();
    dm_rd = 1'b1;
    dm_addr = 32'h44;
    tick();
    vectors++; if (mem_req !== 1'b1) begin miscompares++; $display("FAIL rbusy_grant got=%h exp=1", mem_req); end
    tick();
    #2 rst = 1'b1;
    #1;
    vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL rbusy_mem_req got=%h exp=0", mem_req); end
    vectors++; if (dm_valid !== 1'b0 || if_valid !== 1'b0) begin miscompares++; $display("FAIL rbusy_valids got=%b%b exp=00", dm_valid, if_valid); end
    vectors++; if (err_timeout !== 1'b0) begin miscompares++; $display("FAIL rbusy_err got=%h exp=0", err_timeout); end
    vectors++; if (mem_addr !== 32'h0) begin miscompares++; $display("FAIL rbusy_addr got=%h exp=0", mem_addr); end
    vectors++; if (stall_mem !== 1'b1) begin miscompares++; $display("FAIL rbusy_stall got=%h exp=1", stall_mem); end
    tick();
    tick();
    rst = 1'b0;
    #1;
    vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL rbusy_rel_req got=%h exp=0", mem_req); end
    tick();
    mem_ack = 1'b1;
    mem_rdata = 32'h0BADF00D;
    #1;
    vectors++; if (mem_req !== 1'b1 || mem_addr !== 32'h44 || mem_we !== 1'b0) begin miscompares++; $display("FAIL rbusy_regrant got=%h/%h/%h exp=1/44/0", mem_req, mem_addr, mem_we); end
    tick();
    mem_ack = 1'b0;
    #1;
    vectors++; if (dm_valid !== 1'b1 || dm_rdata !== 32'h0BADF00D) begin miscompares++; $display("FAIL rbusy_done got=%h/%h exp=1/0badf00d", dm_valid, dm_rdata); end
    $display("reset in busy: read 44 re-granted, data %h", dm_rdata);
    tick();
    dm_rd = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_contention();
    test_fairness();
    test_wait_states();
    test_timeout();
    test_reset_busy();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired got=running exp=finished");
    $fatal(1, "watchdog");
  end

endmodule
